alu_share_arb: RTL and testbench

- Time-shares one combinational ALU between N_REQ requesters (e.g. neighbouring PEs or the config/test port) under a round-robin arbiter.
- Issues the winning operation into registered ALU input stage E and captures the ALU result into result stage R.
- Returns the result to the originating requester with valid/ready backpressure.
- Drives the ALU with NOP and zero operands whenever idle, so operand isolation inside the ALU sees no toggling.

---
 rtl/alu_share_arb_pkg.sv | 21 ++
 rtl/alu_share_arb_if.sv | 28 ++
 rtl/alu_share_arb_rr_arb.sv | 32 +++
 rtl/alu_share_arb.sv | 102 ++++++++++
 tb/tb_alu_share_arb.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/alu_share_arb_pkg.sv
// Shared ALU encoding constants and operation record for the ALU share arbiter.
package alu_share_arb_pkg;
  localparam int CONF_ALU_W = 4;
  localparam int WORD_W     = 16;
  localparam int CARRY_W    = 1;
  localparam int DATA_W     = CARRY_W + WORD_W;

  localparam logic [CONF_ALU_W-1:0] CONF_ALU_NOP  = 4'h0;
  localparam logic [CONF_ALU_W-1:0] CONF_ALU_MULT = 4'h6;

  typedef logic [CONF_ALU_W-1:0] conf_t;
  typedef logic [DATA_W-1:0]     data_t;

  typedef struct packed {
    conf_t conf;
    data_t a;
    data_t b;
  } alu_op_t;

  localparam alu_op_t ALU_OP_IDLE = '{conf: CONF_ALU_NOP, a: '0, b: '0};
endpackage

// File: rtl/alu_share_arb_if.sv
// Requester, response and ALU-side bundle of the ALU share arbiter.
interface alu_share_arb_if import alu_share_arb_pkg::*; #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]                 REQ_VALID;
  logic [N_REQ-1:0]                 REQ_READY;
  logic [N_REQ-1:0][CONF_ALU_W-1:0] REQ_CONF;
  logic [N_REQ-1:0][DATA_W-1:0]     REQ_A;
  logic [N_REQ-1:0][DATA_W-1:0]     REQ_B;
  logic [N_REQ-1:0]                 RSP_VALID;
  logic [N_REQ-1:0]                 RSP_READY;
  logic [DATA_W-1:0]                RSP_DATA;
  logic [CONF_ALU_W-1:0]            ALU_CONF;
  logic [DATA_W-1:0]                ALU_IN_A;
  logic [DATA_W-1:0]                ALU_IN_B;
  logic [DATA_W-1:0]                ALU_OUT;
  logic                             BUSY;

  modport slave (
    input  REQ_VALID, REQ_CONF, REQ_A, REQ_B, RSP_READY, ALU_OUT,
    output REQ_READY, RSP_VALID, RSP_DATA, ALU_CONF, ALU_IN_A, ALU_IN_B, BUSY
  );

  modport master (
    output REQ_VALID, REQ_CONF, REQ_A, REQ_B, RSP_READY, ALU_OUT,
    input  REQ_READY, RSP_VALID, RSP_DATA, ALU_CONF, ALU_IN_A, ALU_IN_B, BUSY
  );
endinterface

// File: rtl/alu_share_arb_rr_arb.sv
// Combinational round-robin picker: searches req from ptr+1 (mod N_REQ) upward.
module alu_share_arb_rr_arb #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [ID_W-1:0]  i_ptr,
  input  logic             i_en,
  output logic [N_REQ-1:0] o_gnt,
  output logic [ID_W-1:0]  o_id,
  output logic             o_any
);
  logic [ID_W:0] w_s;

  // Walk offsets from farthest to nearest so the nearest hit overwrites the rest.
  always_comb begin
    o_gnt = '0;
    o_id  = '0;
    o_any = 1'b0;
    w_s   = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      w_s = {1'b0, i_ptr} + (ID_W+1)'(k);
      if (w_s >= (ID_W+1)'(N_REQ)) w_s = w_s - (ID_W+1)'(N_REQ);
      if (i_en && i_req[w_s[ID_W-1:0]]) begin
        o_gnt                  = '0;
        o_gnt[w_s[ID_W-1:0]]   = 1'b1;
        o_id                   = w_s[ID_W-1:0];
        o_any                  = 1'b1;
      end
    end
  end
endmodule

// File: rtl/alu_share_arb.sv
// Round-robin time-sharing of one combinational ALU: issue stage E, result stage R.
// ALU_ARB_MULT2_EN: MULT holds E for a second cycle before it advances.
module alu_share_arb import alu_share_arb_pkg::*; #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic           CLK,
  input  logic           RST,
  alu_share_arb_if.slave bus
);
  alu_op_t           r_e_op;
  logic              r_e_valid;
  logic [ID_W-1:0]   r_e_id;
  logic [DATA_W-1:0] r_r_data;
  logic              r_r_valid;
  logic [ID_W-1:0]   r_r_id;
  logic [ID_W-1:0]   r_ptr;

  logic              w_stall;
  logic              w_adv_e;
  logic              w_gnt_en;
  logic              w_mult_wait;
  logic [N_REQ-1:0]  w_gnt;
  logic [ID_W-1:0]   w_gid;
  logic              w_any;
  logic [N_REQ-1:0]  w_rsp_vld;

`ifdef ALU_ARB_MULT2_EN
  logic r_phase;

  assign w_mult_wait = r_e_valid && (r_e_op.conf == CONF_ALU_MULT) && !r_phase;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)              r_phase <= 1'b0;
    else if (w_adv_e)     r_phase <= 1'b0;
    else if (w_mult_wait) r_phase <= 1'b1;
  end
`else
  assign w_mult_wait = 1'b0;
`endif

  assign w_stall  = r_r_valid & ~bus.RSP_READY[r_r_id];
  assign w_adv_e  = r_e_valid & ~w_stall & ~w_mult_wait;
  assign w_gnt_en = ~RST & ~w_stall & (~r_e_valid | w_adv_e);

  alu_share_arb_rr_arb #(.N_REQ(N_REQ), .ID_W(ID_W)) u_rr_arb (
    .i_req (bus.REQ_VALID),
    .i_ptr (r_ptr),
    .i_en  (w_gnt_en),
    .o_gnt (w_gnt),
    .o_id  (w_gid),
    .o_any (w_any)
  );

  // E drops to NOP/zero whenever it frees up without a new grant, keeping ALU inputs quiet.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_e_op    <= ALU_OP_IDLE;
      r_e_valid <= 1'b0;
      r_e_id    <= '0;
      r_ptr     <= ID_W'(N_REQ-1);
    end else if (w_any) begin
      r_e_op    <= '{conf: bus.REQ_CONF[w_gid], a: bus.REQ_A[w_gid], b: bus.REQ_B[w_gid]};
      r_e_valid <= 1'b1;
      r_e_id    <= w_gid;
      r_ptr     <= w_gid;
    end else if (!r_e_valid || w_adv_e) begin
      r_e_op    <= ALU_OP_IDLE;
      r_e_valid <= 1'b0;
      r_e_id    <= '0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_r_data  <= '0;
      r_r_valid <= 1'b0;
      r_r_id    <= '0;
    end else if (w_adv_e) begin
      r_r_data  <= bus.ALU_OUT;
      r_r_valid <= 1'b1;
      r_r_id    <= r_e_id;
    end else if (r_r_valid && bus.RSP_READY[r_r_id]) begin
      r_r_data  <= '0;
      r_r_valid <= 1'b0;
      r_r_id    <= '0;
    end
  end

  always_comb begin
    w_rsp_vld = '0;
    if (r_r_valid) w_rsp_vld[r_r_id] = 1'b1;
  end

  assign bus.REQ_READY = w_gnt;
  assign bus.RSP_VALID = w_rsp_vld;
  assign bus.RSP_DATA  = r_r_data;
  assign bus.ALU_CONF  = r_e_op.conf;
  assign bus.ALU_IN_A  = r_e_op.a;
  assign bus.ALU_IN_B  = r_e_op.b;
  assign bus.BUSY      = r_e_valid | r_r_valid;
endmodule

// File: tb/tb_alu_share_arb.sv
// Directed bench for alu_share_arb with a small behavioural ALU on the shared port.
module tb_alu_share_arb;
  import alu_share_arb_pkg::*;

  localparam logic [3:0] C_ADD = 4'h1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  alu_share_arb_if #(.N_REQ(4)) bus ();

  alu_share_arb #(.N_REQ(4), .ID_W(2)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  always_comb begin
    case (bus.ALU_CONF)
      C_ADD:         bus.ALU_OUT = 17'(bus.ALU_IN_A[15:0]) + 17'(bus.ALU_IN_B[15:0]);
      CONF_ALU_MULT: bus.ALU_OUT = {1'b0, 16'(bus.ALU_IN_A[15:0] * bus.ALU_IN_B[15:0])};
      default:       bus.ALU_OUT = '0;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [3:0] cf, input logic [16:0] a, input logic [16:0] b);
    bus.REQ_CONF[i] = cf;
    bus.REQ_A[i]    = a;
    bus.REQ_B[i]    = b;
  endtask

  task automatic single(input int i, input logic [3:0] cf, input logic [16:0] a,
                        input logic [16:0] b, input logic [16:0] exp);
    logic [3:0] oh;
    oh = 4'(1 << i);
    set_req(i, cf, a, b);
    bus.REQ_VALID = oh;
    #1 chk("single_ready", 32'(bus.REQ_READY), 32'(oh));
    tick();
    bus.REQ_VALID = 4'h0;
    #1 chk("single_e_conf", 32'(bus.ALU_CONF), 32'(cf));
    chk("single_e_busy", 32'(bus.BUSY), 32'd1);
    chk("single_e_rsp", 32'(bus.RSP_VALID), 32'd0);
    tick();
    chk("single_rsp_vld", 32'(bus.RSP_VALID), 32'(oh));
    chk("single_rsp_data", 32'(bus.RSP_DATA), 32'(exp));
    chk("single_nop_after", 32'(bus.ALU_CONF), 32'(CONF_ALU_NOP));
    tick();
    chk("single_idle", 32'(bus.BUSY), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  exp_rdy [7];
    logic [3:0]  exp_rv  [7];
    logic [16:0] exp_rd  [7];
    exp_rdy = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h0, 4'h0};
    exp_rv  = '{4'h0, 4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h1};
    exp_rd  = '{17'd0, 17'd0, 17'd1, 17'd2, 17'd3, 17'd4, 17'd1};

    bus.REQ_VALID = 4'hF;
    bus.REQ_CONF  = '0;
    bus.REQ_A     = '0;
    bus.REQ_B     = '0;
    bus.RSP_READY = 4'hF;

    // Reset state
    #2;
    chk("rst_req_ready", 32'(bus.REQ_READY), 32'd0);
    chk("rst_rsp_valid", 32'(bus.RSP_VALID), 32'd0);
    chk("rst_rsp_data", 32'(bus.RSP_DATA), 32'd0);
    chk("rst_alu_conf", 32'(bus.ALU_CONF), 32'(CONF_ALU_NOP));
    chk("rst_alu_a", 32'(bus.ALU_IN_A), 32'd0);
    chk("rst_alu_b", 32'(bus.ALU_IN_B), 32'd0);
    chk("rst_busy", 32'(bus.BUSY), 32'd0);
    bus.REQ_VALID = 4'h0;
    tick();
    tick();
    rst = 1'b0;

    // All four requesters held valid: round-robin order and back-to-back results
    for (int i = 0; i < 4; i++) set_req(i, C_ADD, 17'(i), 17'd1);
    for (int c = 0; c < 7; c++) begin
      bus.REQ_VALID = (c <= 4) ? 4'hF : 4'h0;
      #1;
      chk("rr_ready", 32'(bus.REQ_READY), 32'(exp_rdy[c]));
      chk("rr_rsp_valid", 32'(bus.RSP_VALID), 32'(exp_rv[c]));
      if (exp_rv[c] != 4'h0) chk("rr_rsp_data", 32'(bus.RSP_DATA), 32'(exp_rd[c]));
      tick();
    end
    chk("rr_drained", 32'(bus.BUSY), 32'd0);

    // Backpressure on requester 1 with requester 3 already in E and requester 2 waiting
    set_req(1, C_ADD, 17'd10, 17'd3);
    set_req(2, C_ADD, 17'd20, 17'd2);
    set_req(3, C_ADD, 17'd7, 17'd8);
    bus.RSP_READY = 4'b1101;
    bus.REQ_VALID = 4'b0010;
    #1 chk("bp_grant1", 32'(bus.REQ_READY), 32'h2);
    tick();
    bus.REQ_VALID = 4'b1000;
    #1 chk("bp_grant3", 32'(bus.REQ_READY), 32'h8);
    tick();
    bus.REQ_VALID = 4'b0100;
    for (int s = 0; s < 3; s++) begin
      #1;
      chk("bp_rsp_valid", 32'(bus.RSP_VALID), 32'h2);
      chk("bp_rsp_data", 32'(bus.RSP_DATA), 32'd13);
      chk("bp_alu_conf", 32'(bus.ALU_CONF), 32'(C_ADD));
      chk("bp_alu_a", 32'(bus.ALU_IN_A), 32'd7);
      chk("bp_alu_b", 32'(bus.ALU_IN_B), 32'd8);
      chk("bp_ready_low", 32'(bus.REQ_READY), 32'd0);
      tick();
    end
    bus.RSP_READY = 4'hF;
    #1;
    chk("bp_release_grant", 32'(bus.REQ_READY), 32'h4);
    chk("bp_release_rsp", 32'(bus.RSP_VALID), 32'h2);
    chk("bp_release_data", 32'(bus.RSP_DATA), 32'd13);
    tick();
    bus.REQ_VALID = 4'h0;
    #1;
    chk("bp_rsp3_valid", 32'(bus.RSP_VALID), 32'h8);
    chk("bp_rsp3_data", 32'(bus.RSP_DATA), 32'd15);
    chk("bp_e_req2_a", 32'(bus.ALU_IN_A), 32'd20);
    tick();
    chk("bp_rsp2_valid", 32'(bus.RSP_VALID), 32'h4);
    chk("bp_rsp2_data", 32'(bus.RSP_DATA), 32'd22);
    tick();
    chk("bp_drained", 32'(bus.BUSY), 32'd0);

    // Single requests: plain add, NOP passthrough, carry-out boundary
    single(0, C_ADD, 17'd5, 17'd7, 17'd12);
    single(2, CONF_ALU_NOP, 17'd9, 17'd9, 17'd0);
    single(3, C_ADD, 17'h0FFFF, 17'd1, 17'h10000);

    // MULT followed by a waiting ADD
    set_req(0, CONF_ALU_MULT, 17'd3, 17'd4);
    set_req(1, C_ADD, 17'd2, 17'd2);
    bus.REQ_VALID = 4'b0001;
    #1 chk("mul_grant0", 32'(bus.REQ_READY), 32'h1);
    tick();
    bus.REQ_VALID = 4'b0010;
    #1 chk("mul_e_conf", 32'(bus.ALU_CONF), 32'(CONF_ALU_MULT));
`ifdef ALU_ARB_MULT2_EN
    chk("mul_first_ready", 32'(bus.REQ_READY), 32'd0);
    tick();
    chk("mul_second_grant", 32'(bus.REQ_READY), 32'h2);
    chk("mul_second_conf", 32'(bus.ALU_CONF), 32'(CONF_ALU_MULT));
    chk("mul_second_rsp", 32'(bus.RSP_VALID), 32'd0);
    tick();
    bus.REQ_VALID = 4'h0;
`else
    chk("mul_next_grant", 32'(bus.REQ_READY), 32'h2);
    tick();
    bus.REQ_VALID = 4'h0;
`endif
    #1;
    chk("mul_rsp_valid", 32'(bus.RSP_VALID), 32'h1);
    chk("mul_rsp_data", 32'(bus.RSP_DATA), 32'd12);
    chk("mul_then_add", 32'(bus.ALU_CONF), 32'(C_ADD));
    tick();
    chk("mul_add_rsp_valid", 32'(bus.RSP_VALID), 32'h2);
    chk("mul_add_rsp_data", 32'(bus.RSP_DATA), 32'd4);
    tick();

    // Reset with E and R both occupied
    set_req(1, C_ADD, 17'd10, 17'd3);
    set_req(2, C_ADD, 17'd20, 17'd2);
    bus.RSP_READY = 4'h0;
    bus.REQ_VALID = 4'b0010;
    tick();
    bus.REQ_VALID = 4'b0100;
    tick();
    bus.REQ_VALID = 4'h0;
    chk("mid_busy_before", 32'(bus.BUSY), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("mid_rsp_valid", 32'(bus.RSP_VALID), 32'd0);
    chk("mid_rsp_data", 32'(bus.RSP_DATA), 32'd0);
    chk("mid_busy", 32'(bus.BUSY), 32'd0);
    chk("mid_alu_conf", 32'(bus.ALU_CONF), 32'(CONF_ALU_NOP));
    chk("mid_alu_a", 32'(bus.ALU_IN_A), 32'd0);
    chk("mid_alu_b", 32'(bus.ALU_IN_B), 32'd0);
    tick();
    rst = 1'b0;
    bus.RSP_READY = 4'hF;
    for (int s = 0; s < 2; s++) begin
      #1 chk("post_rst_rsp", 32'(bus.RSP_VALID), 32'd0);
      tick();
    end
    bus.REQ_VALID = 4'hF;
    #1 chk("post_rst_grant0", 32'(bus.REQ_READY), 32'h1);
    bus.REQ_VALID = 4'h0;
    #1 chk("withdraw_ready", 32'(bus.REQ_READY), 32'd0);
    tick();
    chk("withdraw_idle", 32'(bus.BUSY), 32'd0);

    // Idle isolation
    for (int s = 0; s < 10; s++) begin
      chk("idle_conf", 32'(bus.ALU_CONF), 32'(CONF_ALU_NOP));
      chk("idle_a", 32'(bus.ALU_IN_A), 32'd0);
      chk("idle_b", 32'(bus.ALU_IN_B), 32'd0);
      chk("idle_busy", 32'(bus.BUSY), 32'd0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
